vc_switch_allocator: RTL and testbench

VC_SWITCH_ALLOCATOR -- requirements
Module: vc_switch_allocator

---
 rtl/vc_switch_allocator.sv | 127 ++++++++++++
 tb/tb_vc_switch_allocator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_switch_allocator.sv
// Switch allocator with per-output round-robin, wormhole packet locking and downstream credit tracking.
// Zero-cycle grant from registered state; a request without a credit for its downstream VC simply waits.
module vc_switch_allocator #(
  parameter int NUM_IN      = 8,
  parameter int NUM_OUT     = 5,
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8,
  localparam int IW = $clog2(NUM_IN),
  localparam int OW = $clog2(NUM_OUT),
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic [NUM_IN-1:0]                        req_valid,
  input  logic [NUM_IN-1:0][OW-1:0]                req_outport,
  input  logic [NUM_IN-1:0][VW-1:0]                req_vc,
  input  logic [NUM_IN-1:0]                        req_head,
  input  logic [NUM_IN-1:0]                        req_tail,
  input  logic [NUM_OUT-1:0][NUM_VCS-1:0]          credit_return,
  output logic [NUM_IN-1:0]                        grant,
  output logic [NUM_OUT-1:0][IW-1:0]               select,
  output logic [NUM_OUT-1:0]                       enable,
  output logic [NUM_OUT-1:0][NUM_VCS-1:0][CW-1:0]  credits,
  output logic [NUM_OUT-1:0]                       locked,
  output logic                                     err_overflow
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state    [NUM_OUT];
  logic [IW-1:0] owner    [NUM_OUT];
  logic [VW-1:0] owner_vc [NUM_OUT];
  logic [IW-1:0] rr_ptr   [NUM_OUT];

  logic [NUM_OUT-1:0][NUM_IN-1:0] elig;
  logic [NUM_OUT-1:0][IW-1:0]     win;
  logic [NUM_OUT-1:0]             found;

  // A locked output only listens to its owner on the VC it latched at the head flit.
  always_comb begin
    elig = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (req_valid[i] && (req_outport[i] == OW'(o)) && (credits[o][req_vc[i]] != '0)) begin
          if (state[o] == IDLE)
            elig[o][i] = req_head[i];
          else
            elig[o][i] = (IW'(i) == owner[o]) && (req_vc[i] == owner_vc[o]);
        end
      end
    end
  end

  always_comb begin
    found = '0;
    win   = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int k = 1; k <= NUM_IN; k++) begin
        if (!found[o] && elig[o][(int'(rr_ptr[o]) + k) % NUM_IN]) begin
          found[o] = 1'b1;
          win[o]   = IW'((int'(rr_ptr[o]) + k) % NUM_IN);
        end
      end
    end
  end

  always_comb begin
    grant  = '0;
    enable = '0;
    select = '0;
    if (!n_rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (found[o]) begin
          enable[o]      = 1'b1;
          select[o]      = win[o];
          grant[win[o]]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    locked = '0;
    for (int o = 0; o < NUM_OUT; o++)
      locked[o] = (state[o] == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        state[o]    <= IDLE;
        owner[o]    <= '0;
        owner_vc[o] <= '0;
        rr_ptr[o]   <= IW'(NUM_IN - 1);
        for (int v = 0; v < NUM_VCS; v++)
          credits[o][v] <= CW'(BUFFER_SIZE);
      end
      err_overflow <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (enable[o]) begin
          rr_ptr[o] <= win[o];
          if (state[o] == IDLE && !req_tail[win[o]]) begin
            state[o]    <= LOCKED;
            owner[o]    <= win[o];
            owner_vc[o] <= req_vc[win[o]];
          end else if (state[o] == LOCKED && req_tail[win[o]]) begin
            state[o] <= IDLE;
          end
        end
        // Grant and return in the same cycle cancel; a return into a full counter is a protocol error.
        for (int v = 0; v < NUM_VCS; v++) begin
          if (enable[o] && (req_vc[win[o]] == VW'(v)) && !credit_return[o][v]) begin
            credits[o][v] <= credits[o][v] - CW'(1);
          end else if (credit_return[o][v] && !(enable[o] && (req_vc[win[o]] == VW'(v)))) begin
            if (credits[o][v] == CW'(BUFFER_SIZE))
              err_overflow <= 1'b1;
            else
              credits[o][v] <= credits[o][v] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Directed scenarios plus randomized traffic checked against a packet-level reference model.
module tb_vc_switch_allocator;
  localparam int NI = 8;
  localparam int NO = 5;
  localparam int NV = 2;
  localparam int BS = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic [NI-1:0]             req_valid, req_head, req_tail;
  logic [NI-1:0][2:0]        req_outport;
  logic [NI-1:0][0:0]        req_vc;
  logic [NO-1:0][NV-1:0]     credit_return;
  logic [NI-1:0]             grant;
  logic [NO-1:0][2:0]        select;
  logic [NO-1:0]             enable;
  logic [NO-1:0][NV-1:0][3:0] credits;
  logic [NO-1:0]             locked;
  logic                      err_overflow;

  int checks = 0;
  int failures = 0;

  vc_switch_allocator dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_outport(req_outport),
    .req_vc(req_vc), .req_head(req_head), .req_tail(req_tail),
    .credit_return(credit_return), .grant(grant), .select(select), .enable(enable),
    .credits(credits), .locked(locked), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_lock [NO];
  int m_owner [NO];
  int m_ovc [NO];
  int m_ptr [NO];
  int m_cred [NO][NV];
  bit m_err;
  bit m_en [NO];
  int m_win [NO];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid = '0; req_head = '0; req_tail = '0;
    req_outport = '0; req_vc = '0; credit_return = '0;
  endtask

  task automatic do_reset;
    n_rst = 1'b1;
    clear_inputs();
    step();
    n_rst = 1'b0;
  endtask

  function automatic logic [NO-1:0][NV-1:0][3:0] all_full();
    logic [NO-1:0][NV-1:0][3:0] c;
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++)
        c[o][v] = 4'(BS);
    return c;
  endfunction

  task automatic model_init;
    for (int o = 0; o < NO; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_ovc[o] = 0; m_ptr[o] = NI - 1;
      for (int v = 0; v < NV; v++) m_cred[o][v] = BS;
    end
    m_err = 0;
  endtask

  // Winner is the candidate at the smallest round-robin distance past the pointer.
  task automatic model_eval;
    for (int o = 0; o < NO; o++) begin
      int bestd;
      bestd = NI;
      m_en[o] = 0;
      m_win[o] = 0;
      for (int i = 0; i < NI; i++) begin
        bit cand;
        int d;
        if (!m_lock[o])
          cand = req_valid[i] && req_head[i] && int'(req_outport[i]) == o && m_cred[o][int'(req_vc[i])] > 0;
        else
          cand = i == m_owner[o] && req_valid[i] && int'(req_outport[i]) == o &&
                 int'(req_vc[i]) == m_ovc[o] && m_cred[o][m_ovc[o]] > 0;
        d = (i - m_ptr[o] - 1 + NI) % NI;
        if (cand && d < bestd) begin
          bestd = d; m_win[o] = i; m_en[o] = 1;
        end
      end
      if (n_rst) m_en[o] = 0;
    end
  endtask

  task automatic model_update;
    if (n_rst) begin
      model_init();
    end else begin
      for (int o = 0; o < NO; o++) begin
        if (m_en[o]) begin
          m_ptr[o] = m_win[o];
          if (!m_lock[o] && !req_tail[m_win[o]]) begin
            m_lock[o] = 1; m_owner[o] = m_win[o]; m_ovc[o] = int'(req_vc[m_win[o]]);
          end else if (m_lock[o] && req_tail[m_win[o]]) begin
            m_lock[o] = 0;
          end
        end
        for (int v = 0; v < NV; v++) begin
          int c;
          c = m_cred[o][v] + int'(credit_return[o][v]);
          if (m_en[o] && int'(req_vc[m_win[o]]) == v) c = c - 1;
          if (c > BS) begin
            c = BS; m_err = 1;
          end
          m_cred[o][v] = c;
        end
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b1;
    req_valid = 8'hFF; req_head = 8'hFF; req_tail = 8'hFF;
    #1;
    checks++; if (grant !== 8'h00) begin failures++; $display("FAIL reset_grant got=%h exp=00", grant); end
    checks++; if (enable !== 5'h00) begin failures++; $display("FAIL reset_enable got=%h exp=00", enable); end
    checks++; if (select !== '0) begin failures++; $display("FAIL reset_select got=%h exp=0", select); end
    step();
    checks++; if (locked !== 5'h00) begin failures++; $display("FAIL reset_locked got=%h exp=00", locked); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overflow); end
    checks++; if (credits !== all_full()) begin failures++; $display("FAIL reset_credits got=%h exp=%h", credits, all_full()); end
    n_rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_round_robin;
    do_reset();
    req_valid = 8'h09; req_head = 8'h09; req_tail = 8'h09;
    req_outport[0] = 3'd2; req_outport[3] = 3'd2;
    #1;
    checks++; if (grant !== 8'h01) begin failures++; $display("FAIL rr_first got=%h exp=01", grant); end
    checks++; if (enable !== 5'b00100) begin failures++; $display("FAIL rr_enable got=%h exp=04", enable); end
    checks++; if (select[2] !== 3'd0) begin failures++; $display("FAIL rr_select0 got=%0d exp=0", select[2]); end
    step(); #1;
    checks++; if (grant !== 8'h08) begin failures++; $display("FAIL rr_second got=%h exp=08", grant); end
    checks++; if (select[2] !== 3'd3) begin failures++; $display("FAIL rr_select3 got=%0d exp=3", select[2]); end
    step(); #1;
    checks++; if (grant !== 8'h01) begin failures++; $display("FAIL rr_third got=%h exp=01", grant); end
    step(); clear_inputs(); #1;
    checks++; if (credits[2][0] !== 4'd5) begin failures++; $display("FAIL rr_credits got=%0d exp=5", credits[2][0]); end
  endtask

  task automatic test_packet_lock;
    do_reset();
    req_valid = 8'h06;
    req_outport[1] = 3'd0; req_vc[1] = 1'b1; req_head[1] = 1'b1; req_tail[1] = 1'b0;
    req_outport[2] = 3'd0; req_vc[2] = 1'b0; req_head[2] = 1'b1; req_tail[2] = 1'b1;
    #1;
    checks++; if (grant !== 8'h02) begin failures++; $display("FAIL lock_head got=%h exp=02", grant); end
    checks++; if (locked[0] !== 1'b0) begin failures++; $display("FAIL lock_before got=%b exp=0", locked[0]); end
    step(); req_head[1] = 1'b0; #1;
    checks++; if (grant !== 8'h02) begin failures++; $display("FAIL lock_body got=%h exp=02", grant); end
    checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL lock_held1 got=%b exp=1", locked[0]); end
    step(); req_tail[1] = 1'b1; #1;
    checks++; if (grant !== 8'h02) begin failures++; $display("FAIL lock_tail got=%h exp=02", grant); end
    checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL lock_held2 got=%b exp=1", locked[0]); end
    step(); req_valid[1] = 1'b0; #1;
    checks++; if (grant !== 8'h04) begin failures++; $display("FAIL lock_next got=%h exp=04", grant); end
    checks++; if (locked[0] !== 1'b0) begin failures++; $display("FAIL lock_released got=%b exp=0", locked[0]); end
    step(); clear_inputs(); #1;
    checks++; if (credits[0][1] !== 4'd5) begin failures++; $display("FAIL lock_cred_vc1 got=%0d exp=5", credits[0][1]); end
    checks++; if (credits[0][0] !== 4'd7) begin failures++; $display("FAIL lock_cred_vc0 got=%0d exp=7", credits[0][0]); end
  endtask

  task automatic test_credit_exhaust;
    do_reset();
    req_valid[5] = 1'b1; req_head[5] = 1'b1; req_tail[5] = 1'b1; req_outport[5] = 3'd4;
    for (int n = 0; n < BS; n++) begin
      #1;
      checks++; if (grant !== 8'h20) begin failures++; $display("FAIL exhaust_grant%0d got=%h exp=20", n, grant); end
      step();
    end
    #1;
    checks++; if (credits[4][0] !== 4'd0) begin failures++; $display("FAIL exhaust_zero got=%0d exp=0", credits[4][0]); end
    checks++; if (grant !== 8'h00) begin failures++; $display("FAIL exhaust_blocked got=%h exp=00", grant); end
    credit_return[4][0] = 1'b1; #1;
    checks++; if (grant !== 8'h00) begin failures++; $display("FAIL exhaust_same_cycle got=%h exp=00", grant); end
    step(); credit_return = '0; #1;
    checks++; if (credits[4][0] !== 4'd1) begin failures++; $display("FAIL exhaust_one got=%0d exp=1", credits[4][0]); end
    checks++; if (grant !== 8'h20) begin failures++; $display("FAIL exhaust_regrant got=%h exp=20", grant); end
    step(); clear_inputs();
  endtask

  task automatic test_simul_return;
    do_reset();
    req_valid[0] = 1'b1; req_head[0] = 1'b1; req_tail[0] = 1'b1; req_outport[0] = 3'd1;
    repeat (3) step();
    #1;
    checks++; if (credits[1][0] !== 4'd5) begin failures++; $display("FAIL simul_pre got=%0d exp=5", credits[1][0]); end
    credit_return[1][0] = 1'b1; #1;
    checks++; if (grant !== 8'h01) begin failures++; $display("FAIL simul_grant got=%h exp=01", grant); end
    step(); clear_inputs(); #1;
    checks++; if (credits[1][0] !== 4'd5) begin failures++; $display("FAIL simul_post got=%0d exp=5", credits[1][0]); end
  endtask

  task automatic test_overflow;
    do_reset();
    credit_return[3][1] = 1'b1;
    step(); credit_return = '0; #1;
    checks++; if (credits[3][1] !== 4'd8) begin failures++; $display("FAIL ovf_hold got=%0d exp=8", credits[3][1]); end
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", err_overflow); end
    repeat (5) step();
    #1;
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", err_overflow); end
    do_reset(); #1;
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", err_overflow); end
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    req_valid[4] = 1'b1; req_head[4] = 1'b1; req_tail[4] = 1'b0; req_outport[4] = 3'd0; req_vc[4] = 1'b1;
    #1;
    checks++; if (grant !== 8'h10) begin failures++; $display("FAIL mid_head got=%h exp=10", grant); end
    step(); req_head[4] = 1'b0; #1;
    checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL mid_locked got=%b exp=1", locked[0]); end
    checks++; if (credits[0][1] !== 4'd7) begin failures++; $display("FAIL mid_cred got=%0d exp=7", credits[0][1]); end
    n_rst = 1'b1; #1;
    checks++; if (grant !== 8'h00) begin failures++; $display("FAIL mid_rst_grant got=%h exp=00", grant); end
    checks++; if (enable !== 5'h00) begin failures++; $display("FAIL mid_rst_enable got=%h exp=00", enable); end
    step(); n_rst = 1'b0;
    clear_inputs();
    req_valid[6] = 1'b1; req_head[6] = 1'b1; req_tail[6] = 1'b1; req_outport[6] = 3'd0;
    #1;
    checks++; if (locked[0] !== 1'b0) begin failures++; $display("FAIL mid_unlocked got=%b exp=0", locked[0]); end
    checks++; if (credits !== all_full()) begin failures++; $display("FAIL mid_credits got=%h exp=%h", credits, all_full()); end
    checks++; if (grant !== 8'h40) begin failures++; $display("FAIL mid_new_head got=%h exp=40", grant); end
    step(); clear_inputs();
  endtask

  task automatic test_random;
    logic [NI-1:0]          exp_grant;
    logic [NO-1:0]          exp_en, exp_lock;
    logic [NO-1:0][2:0]     exp_sel;
    logic [NO-1:0][NV-1:0][3:0] exp_cred;
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_rst = ($urandom_range(0, 99) == 0);
      req_valid = NI'($urandom);
      req_head = NI'($urandom);
      req_tail = NI'($urandom);
      for (int i = 0; i < NI; i++) begin
        req_outport[i] = 3'($urandom_range(0, NO - 1));
        req_vc[i] = 1'($urandom_range(0, 1));
      end
      for (int o = 0; o < NO; o++)
        for (int v = 0; v < NV; v++)
          credit_return[o][v] = ($urandom_range(0, 2) == 0);
      #1;
      model_eval();
      exp_grant = '0; exp_en = '0; exp_sel = '0; exp_lock = '0;
      for (int o = 0; o < NO; o++) begin
        exp_lock[o] = m_lock[o];
        for (int v = 0; v < NV; v++) exp_cred[o][v] = 4'(m_cred[o][v]);
        if (m_en[o]) begin
          exp_en[o] = 1'b1; exp_sel[o] = 3'(m_win[o]); exp_grant[m_win[o]] = 1'b1;
        end
      end
      checks++; if (grant !== exp_grant) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%h exp=%h", cyc, grant, exp_grant); end
      checks++; if (enable !== exp_en) begin failures++; $display("FAIL rnd_enable cyc=%0d got=%h exp=%h", cyc, enable, exp_en); end
      checks++; if (select !== exp_sel) begin failures++; $display("FAIL rnd_select cyc=%0d got=%h exp=%h", cyc, select, exp_sel); end
      checks++; if (locked !== exp_lock) begin failures++; $display("FAIL rnd_locked cyc=%0d got=%h exp=%h", cyc, locked, exp_lock); end
      checks++; if (credits !== exp_cred) begin failures++; $display("FAIL rnd_credits cyc=%0d got=%h exp=%h", cyc, credits, exp_cred); end
      checks++; if (err_overflow !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_overflow, m_err); end
      @(posedge clk);
      model_update();
      #1;
    end
    n_rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_exhaust();
    test_simul_return();
    test_overflow();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
